manual_step_clock: RTL and testbench

- Produces the debounced single-step clock that drives the CPU clock multiplexer's secondary input (inputB).
- The multiplexer selects inputB while the current opcode is IN (6'b011101), OUT (6'b100000) or HLT (6'b011100). During those instructions, the CPU advances only when an operator press is debounced and turned into one clean clock pulse.
- Sits between the board push-button and the clock multiplexer; shares the current opcode with it.

---
 rtl/manual_step_clock.sv | 197 +++++++++++++++++++
 tb/tb_manual_step_clock.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/manual_step_clock.sv
`default_nettype none
// ============================================================================
//  Module      : manual_step_clock
//  Description : Debounced single-step clock for the CPU clock multiplexer's
//                secondary input. While the current opcode is IN, OUT or HLT
//                an operator press on the board push-button is synchronized,
//                debounced and turned into one clean manual_clock pulse of
//                HIGH_CYCLES cycles.
//                Optional macro STEP_AUTOREPEAT_EN: a held button re-steps
//                every REPEAT_CYCLES cycles while the opcode stays armed.
//  Revision    : 1.0 - initial release
// ============================================================================
module manual_step_clock #(
    parameter int DEBOUNCE_CYCLES   = 50000,
    parameter int HIGH_CYCLES       = 4,
    parameter int COUNT_WIDTH       = 20,
    parameter int BUTTON_ACTIVE_LOW = 1,
    parameter int REPEAT_CYCLES     = 500000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       button,
    input  logic [5:0] operation,
    output logic       manual_clock,
    output logic       step_pulse,
    output logic       busy,
    output logic [7:0] step_count
);

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_PRESS_WAIT   = 3'd1,
        S_HIGH         = 3'd2,
        S_HELD         = 3'd3,
        S_RELEASE_WAIT = 3'd4
    } state_t;

    localparam logic [5:0] C_OP_IN  = 6'b011101;
    localparam logic [5:0] C_OP_OUT = 6'b100000;
    localparam logic [5:0] C_OP_HLT = 6'b011100;

    localparam logic [COUNT_WIDTH-1:0] C_DEBOUNCE_LAST = COUNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] C_HIGH_LAST     = COUNT_WIDTH'(HIGH_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] C_COUNT_ONE     = COUNT_WIDTH'(1);
`ifdef STEP_AUTOREPEAT_EN
    localparam logic [COUNT_WIDTH-1:0] C_REPEAT_LAST   = COUNT_WIDTH'(REPEAT_CYCLES - 1);
`endif

    // Largest terminal count the shared counter must reach in any build.
    localparam int C_MAX_A      = (DEBOUNCE_CYCLES > HIGH_CYCLES) ? DEBOUNCE_CYCLES : HIGH_CYCLES;
    localparam int C_MAX_CYCLES = (C_MAX_A > REPEAT_CYCLES) ? C_MAX_A : REPEAT_CYCLES;

    // Refuse to elaborate with a counter too narrow for its terminal values.
    generate
        if (C_MAX_CYCLES > (1 << COUNT_WIDTH)) begin : g_count_width_check
            $error("manual_step_clock: COUNT_WIDTH too small for cycle parameters");
        end
    endgenerate

    state_t                  state_q,        state_d;
    logic [COUNT_WIDTH-1:0]  counter_q,      counter_d;
    logic [1:0]              sync_q,         sync_d;
    logic                    manual_clock_q, manual_clock_d;
    logic                    step_pulse_q,   step_pulse_d;
    logic [7:0]              step_count_q,   step_count_d;
    logic                    ignore_q,       ignore_d;

    logic w_btn_norm;
    logic w_btn_s;
    logic w_armed;

    // Normalize polarity so 1 always means pressed, then feed the synchronizer.
    always_comb begin
        w_btn_norm = (BUTTON_ACTIVE_LOW != 0) ? ~button : button;
        sync_d     = {sync_q[0], w_btn_norm};
        w_btn_s    = sync_q[1];
        w_armed    = (operation == C_OP_IN) || (operation == C_OP_OUT) ||
                     (operation == C_OP_HLT);
    end

    // Step sequencer: debounce press, emit pulse, wait for debounced release.
    always_comb begin
        state_d        = state_q;
        counter_d      = counter_q;
        manual_clock_d = manual_clock_q;
        step_pulse_d   = 1'b0;
        step_count_d   = step_count_q;
        ignore_d       = ignore_q;

        unique case (state_q)
            S_IDLE: begin
                // A press seen while not armed is latched as "ignore" until the
                // button is released, so arming mid-hold cannot trigger a step.
                if (!w_btn_s) begin
                    ignore_d = 1'b0;
                end else if (!w_armed) begin
                    ignore_d = 1'b1;
                end else if (!ignore_q) begin
                    state_d   = S_PRESS_WAIT;
                    counter_d = '0;
                end
            end

            S_PRESS_WAIT: begin
                if (!w_btn_s) begin
                    state_d   = S_IDLE;
                    counter_d = '0;
                end else if (counter_q == C_DEBOUNCE_LAST) begin
                    state_d        = S_HIGH;
                    counter_d      = '0;
                    manual_clock_d = 1'b1;
                    step_pulse_d   = 1'b1;
                    step_count_d   = step_count_q + 8'd1;
                end else begin
                    counter_d = counter_q + C_COUNT_ONE;
                end
            end

            S_HIGH: begin
                manual_clock_d = 1'b1;
                if (counter_q == C_HIGH_LAST) begin
                    state_d        = S_HELD;
                    counter_d      = '0;
                    manual_clock_d = 1'b0;
                end else begin
                    counter_d = counter_q + C_COUNT_ONE;
                end
            end

            S_HELD: begin
                if (!w_btn_s) begin
                    state_d   = S_RELEASE_WAIT;
                    counter_d = '0;
                end
`ifdef STEP_AUTOREPEAT_EN
                else if (counter_q == C_REPEAT_LAST) begin
                    counter_d = '0;
                    if (w_armed) begin
                        state_d        = S_HIGH;
                        manual_clock_d = 1'b1;
                        step_pulse_d   = 1'b1;
                        step_count_d   = step_count_q + 8'd1;
                    end
                end else begin
                    counter_d = counter_q + C_COUNT_ONE;
                end
`endif
            end

            S_RELEASE_WAIT: begin
                if (w_btn_s) begin
                    state_d   = S_HELD;
                    counter_d = '0;
                end else if (counter_q == C_DEBOUNCE_LAST) begin
                    state_d   = S_IDLE;
                    counter_d = '0;
                end else begin
                    counter_d = counter_q + C_COUNT_ONE;
                end
            end

            default: begin
                state_d        = S_IDLE;
                counter_d      = '0;
                manual_clock_d = 1'b0;
            end
        endcase
    end

    // State, counter, synchronizer and output registers; async active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            counter_q      <= '0;
            sync_q         <= 2'b00;
            manual_clock_q <= 1'b0;
            step_pulse_q   <= 1'b0;
            step_count_q   <= 8'd0;
            ignore_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            counter_q      <= counter_d;
            sync_q         <= sync_d;
            manual_clock_q <= manual_clock_d;
            step_pulse_q   <= step_pulse_d;
            step_count_q   <= step_count_d;
            ignore_q       <= ignore_d;
        end
    end

    assign manual_clock = manual_clock_q;
    assign step_pulse   = step_pulse_q;
    assign busy         = (state_q != S_IDLE);
    assign step_count   = step_count_q;

endmodule
`default_nettype wire

// File: tb/tb_manual_step_clock.sv
`default_nettype none
// ============================================================================
//  Module      : tb_manual_step_clock
//  Description : Directed self-checking bench for manual_step_clock with
//                DEBOUNCE_CYCLES=4, HIGH_CYCLES=2, active-high button,
//                REPEAT_CYCLES=8. Autorepeat expectations follow the
//                STEP_AUTOREPEAT_EN macro.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_manual_step_clock;

    logic       clock;
    logic       reset;
    logic       button;
    logic [5:0] operation;
    logic       manual_clock;
    logic       step_pulse;
    logic       busy;
    logic [7:0] step_count;

    int total = 0;
    int bad   = 0;

    manual_step_clock #(
        .DEBOUNCE_CYCLES   (4),
        .HIGH_CYCLES       (2),
        .COUNT_WIDTH       (20),
        .BUTTON_ACTIVE_LOW (0),
        .REPEAT_CYCLES     (8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .button       (button),
        .operation    (operation),
        .manual_clock (manual_clock),
        .step_pulse   (step_pulse),
        .busy         (busy),
        .step_count   (step_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One active edge, then return to the sampling point on the falling edge.
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic apply_reset();
        reset  = 1'b0;
        button = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int n = 0; n < 6; n++) begin
            button = n[0];
            tick();
            total++;
            if ({manual_clock, step_pulse, busy, step_count} !== 11'd0) begin
                bad++;
                $display("FAIL reset_hold cycle %0d: got mc=%b sp=%b busy=%b cnt=%0d want all 0",
                         n, manual_clock, step_pulse, busy, step_count);
            end
        end
        button = 1'b0;
        reset  = 1'b1;
        for (int n = 0; n < 4; n++) begin
            tick();
            total++;
            if ({manual_clock, step_pulse, busy, step_count} !== 11'd0) begin
                bad++;
                $display("FAIL reset_release cycle %0d: got mc=%b sp=%b busy=%b cnt=%0d want all 0",
                         n, manual_clock, step_pulse, busy, step_count);
            end
        end
    endtask

    task automatic test_clean_press();
        logic exp_mc, exp_sp, exp_busy;
        apply_reset();
        operation = 6'b011101;
        button    = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            exp_mc   = (n == 7) || (n == 8);
            exp_sp   = (n == 7);
            exp_busy = (n >= 3);
            total++;
            if ({manual_clock, step_pulse, busy} !== {exp_mc, exp_sp, exp_busy}) begin
                bad++;
                $display("FAIL clean_press edge %0d: got mc=%b sp=%b busy=%b want mc=%b sp=%b busy=%b",
                         n, manual_clock, step_pulse, busy, exp_mc, exp_sp, exp_busy);
            end
        end
        total++;
        if (step_count !== 8'd1) begin
            bad++;
            $display("FAIL clean_count: got %0d want 1", step_count);
        end
        button = 1'b0;
        for (int n = 0; n < 10; n++) tick();
        total++;
        if ({busy, manual_clock} !== 2'b00) begin
            bad++;
            $display("FAIL clean_release: got busy=%b mc=%b want 0 0", busy, manual_clock);
        end
    endtask

    task automatic test_bounce();
        apply_reset();
        operation = 6'b011100;
        for (int n = 1; n <= 17; n++) begin
            button = (n == 1) || (n == 2) || (n == 4) || (n == 5);
            tick();
            total++;
            if ({manual_clock, step_pulse} !== 2'b00) begin
                bad++;
                $display("FAIL bounce edge %0d: got mc=%b sp=%b want 0 0", n, manual_clock, step_pulse);
            end
        end
        total++;
        if ({busy, step_count} !== 9'd0) begin
            bad++;
            $display("FAIL bounce_end: got busy=%b cnt=%0d want 0 0", busy, step_count);
        end
    endtask

    task automatic test_not_armed();
        logic exp_mc;
        apply_reset();
        operation = 6'b000001;
        button    = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            if (n == 21) operation = 6'b100000;
            tick();
            total++;
            if ({manual_clock, step_pulse, busy} !== 3'b000) begin
                bad++;
                $display("FAIL not_armed edge %0d: got mc=%b sp=%b busy=%b want 0 0 0",
                         n, manual_clock, step_pulse, busy);
            end
        end
        button = 1'b0;
        for (int n = 0; n < 5; n++) tick();
        button = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            tick();
            exp_mc = (n == 7) || (n == 8);
            total++;
            if (manual_clock !== exp_mc) begin
                bad++;
                $display("FAIL repress_mc edge %0d: got %b want %b", n, manual_clock, exp_mc);
            end
        end
        total++;
        if (step_count !== 8'd1) begin
            bad++;
            $display("FAIL repress_count: got %0d want 1", step_count);
        end
        button = 1'b0;
        for (int n = 0; n < 10; n++) tick();
    endtask

    task automatic test_reset_mid_pulse();
        apply_reset();
        operation = 6'b011101;
        button    = 1'b1;
        for (int n = 0; n < 7; n++) tick();
        total++;
        if ({manual_clock, step_count} !== {1'b1, 8'd1}) begin
            bad++;
            $display("FAIL mid_pulse_pre: got mc=%b cnt=%0d want 1 1", manual_clock, step_count);
        end
        #2 reset = 1'b0;
        #1;
        total++;
        if ({manual_clock, busy, step_count} !== 10'd0) begin
            bad++;
            $display("FAIL mid_pulse_async: got mc=%b busy=%b cnt=%0d want 0 0 0",
                     manual_clock, busy, step_count);
        end
        button = 1'b0;
        @(negedge clock);
        tick();
        reset = 1'b1;
        tick();
        button = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (n == 7) begin
                total++;
                if ({manual_clock, step_pulse} !== 2'b11) begin
                    bad++;
                    $display("FAIL post_reset_pulse: got mc=%b sp=%b want 1 1", manual_clock, step_pulse);
                end
            end
        end
        total++;
        if (step_count !== 8'd1) begin
            bad++;
            $display("FAIL post_reset_count: got %0d want 1", step_count);
        end
        button = 1'b0;
        for (int n = 0; n < 10; n++) tick();
    endtask

    task automatic test_held_button();
        logic exp_mc, exp_sp;
        logic [7:0] exp_cnt;
        apply_reset();
        operation = 6'b011101;
        button    = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            tick();
`ifdef STEP_AUTOREPEAT_EN
            exp_mc = (n >= 7) && (((n - 7) % 10) < 2);
            exp_sp = (n >= 7) && (((n - 7) % 10) == 0);
`else
            exp_mc = (n == 7) || (n == 8);
            exp_sp = (n == 7);
`endif
            total++;
            if ({manual_clock, step_pulse} !== {exp_mc, exp_sp}) begin
                bad++;
                $display("FAIL held edge %0d: got mc=%b sp=%b want mc=%b sp=%b",
                         n, manual_clock, step_pulse, exp_mc, exp_sp);
            end
        end
`ifdef STEP_AUTOREPEAT_EN
        exp_cnt = 8'd4;
`else
        exp_cnt = 8'd1;
`endif
        total++;
        if (step_count !== exp_cnt) begin
            bad++;
            $display("FAIL held_count: got %0d want %0d", step_count, exp_cnt);
        end
        button = 1'b0;
        for (int n = 0; n < 12; n++) tick();
        total++;
        if ({busy, manual_clock, step_count} !== {2'b00, exp_cnt}) begin
            bad++;
            $display("FAIL held_release: got busy=%b mc=%b cnt=%0d want 0 0 %0d",
                     busy, manual_clock, step_count, exp_cnt);
        end
    endtask

    initial begin
        reset     = 1'b0;
        button    = 1'b0;
        operation = 6'b000000;
        @(negedge clock);
        test_reset();
        test_clean_press();
        test_bounce();
        test_not_armed();
        test_reset_mid_pulse();
        test_held_button();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
